// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch stage with a busy scoreboard, writeback bypass
// and a registered valid/ready operand bundle toward EX.
module operand_fetch #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic [XLEN-1:0]   wb_rwd,
  input  logic              sq_valid,
  input  logic [REG_AW-1:0] sq_rd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [31:0]       ex_instr,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_we
);
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] OP = 7'b0110011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  logic [2**REG_AW-1:0] busy, busy_n;
  logic [6:0]           opc;
  logic [REG_AW-1:0]    rd;
  logic                 use1, use2, we, hit1, hit2, hitd, stall, cap;
  logic [XLEN-1:0]      op1, op2;
  assign opc  = in_instr[6:0];
  assign rd   = in_instr[7 +: REG_AW];
  assign rs1  = in_instr[15 +: REG_AW];
  assign rs2  = in_instr[20 +: REG_AW];
  assign use1 = !(opc == LUI || opc == AUIPC || opc == JAL);
  assign use2 = opc == OP || opc == STORE || opc == BRANCH;
  assign we   = !(opc == STORE || opc == BRANCH) && rd != '0;
  assign hit1 = wb_write && wb_rw == rs1;
  assign hit2 = wb_write && wb_rw == rs2;
  assign hitd = wb_write && wb_rw == rd;
  // busy[0] is held at zero, so x0 never needs an explicit ready term
  assign stall = in_valid && ((use1 && busy[rs1] && !hit1) ||
                              (use2 && busy[rs2] && !hit2) ||
                              (we && busy[rd] && !hitd));
  assign in_ready = reset && !flush && !stall && (!ex_valid || ex_ready);
  assign cap = in_valid && in_ready;
  assign op1 = rs1 == '0 ? '0 : hit1 ? wb_rwd : rd1;
  assign op2 = rs2 == '0 ? '0 : hit2 ? wb_rwd : rd2;
  // clears first, then the capture's set so a same-register set wins
  always_comb begin
    busy_n = busy;
    if (wb_write) busy_n[wb_rw] = 1'b0;
    if (sq_valid) busy_n[sq_rd] = 1'b0;
    if (flush && ex_valid && ex_we) busy_n[ex_rd] = 1'b0;
    if (cap && we) busy_n[rd] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= '0;
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_instr <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
    end else begin
      busy <= busy_n;
      if (cap) begin
        ex_valid <= 1'b1;
        ex_pc    <= in_pc;
        ex_instr <= in_instr;
        ex_op1   <= op1;
        ex_op2   <= op2;
        ex_rd    <= rd;
        ex_we    <= we;
      end else if (flush || ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end
endmodule
